// File: rtl/store_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_unit_pkg
// Shared types and constants for the MEM-stage store engine.
//   STORE_XLEN       data/address width supported by the store path (32)
//   STORE_NUM_BYTES  byte lanes per word (byte-mask width)
//   store_funct3_t   RV32I store width encodings (SB/SH/SW), the write-side
//                    counterpart of the load funct3 encodings
//   word_addr()      clears the byte offset of an address
// -----------------------------------------------------------------------------
package store_unit_pkg;

  localparam int STORE_XLEN      = 32;
  localparam int STORE_NUM_BYTES = STORE_XLEN / 8;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  function automatic logic [STORE_XLEN-1:0] word_addr(input logic [STORE_XLEN-1:0] addr);
    return {addr[STORE_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/store_unit_if.sv
// -----------------------------------------------------------------------------
// store_unit_if
// Bundles the MEM-stage store request and the data-cache write port.
//   req_valid/req_funct3/req_addr/req_data  store request from MEM
//   req_ready/stall/misaligned/busy         status back to the pipeline
//   dmem_write/address/wdata/mbe            registered write to the data cache
//   dmem_resp                               cache took the write
// Modports:
//   master  pipeline + cache side (drives requests and dmem_resp)
//   slave   the store unit
// -----------------------------------------------------------------------------
interface store_unit_if;
  import store_unit_pkg::*;

  logic                       req_valid;
  logic [2:0]                 req_funct3;
  logic [STORE_XLEN-1:0]      req_addr;
  logic [STORE_XLEN-1:0]      req_data;
  logic                       req_ready;
  logic                       stall;
  logic                       misaligned;
  logic                       busy;

  logic                       dmem_write;
  logic [STORE_XLEN-1:0]      dmem_address;
  logic [STORE_XLEN-1:0]      dmem_wdata;
  logic [STORE_NUM_BYTES-1:0] dmem_mbe;
  logic                       dmem_resp;

  modport master (
    output req_valid, req_funct3, req_addr, req_data, dmem_resp,
    input  req_ready, stall, misaligned, busy,
           dmem_write, dmem_address, dmem_wdata, dmem_mbe
  );

  modport slave (
    input  req_valid, req_funct3, req_addr, req_data, dmem_resp,
    output req_ready, stall, misaligned, busy,
           dmem_write, dmem_address, dmem_wdata, dmem_mbe
  );

endinterface

// File: rtl/store_unit_align.sv
// -----------------------------------------------------------------------------
// store_align
// Purely combinational lane steering for SB/SH/SW.
//   funct3    store width encoding
//   addr_off  byte offset within the word (req_addr[1:0])
//   data      rs2 value
//   mbe       byte enables for the addressed lanes
//   wdata     store data replicated across all lanes
//   illegal   unaligned SH/SW or an unknown width encoding
// -----------------------------------------------------------------------------
module store_align
  import store_unit_pkg::*;
(
  input  logic [2:0]                 funct3,
  input  logic [1:0]                 addr_off,
  input  logic [STORE_XLEN-1:0]      data,
  output logic [STORE_NUM_BYTES-1:0] mbe,
  output logic [STORE_XLEN-1:0]      wdata,
  output logic                       illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    mbe     = '0;
    wdata   = data;
    illegal = 1'b0;
    case (funct3)
      sb: begin
        mbe   = 4'b0001 << addr_off;
        wdata = {4{data[7:0]}};
      end
      sh: begin
        mbe     = addr_off[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data[15:0]}};
        illegal = addr_off[0];
      end
      sw: begin
        mbe     = 4'b1111;
        wdata   = data;
        illegal = (addr_off != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// -----------------------------------------------------------------------------
// store_unit
// MEM-stage store engine for the RV32I pipeline. Checks alignment of SB/SH/SW,
// forms the word address, replicated data and byte mask, drives the data-cache
// write handshake and stalls the pipeline until the write is taken.
// Ports:
//   clk   system clock, all state on the rising edge
//   rst   synchronous, active-high reset
//   bus   store_unit_if.slave (request, status and dmem write port)
// Parameters:
//   XLEN       data/address width; only 32 is supported
//   NUM_BYTES  XLEN/8, byte-mask width
// Configuration:
//   STORE_BUFFER_EN  one-entry posted store buffer: the pipeline is released
//                    in the accept cycle and back-to-back stores chain on
//                    dmem_resp. Undefined: fully blocking stores.
// -----------------------------------------------------------------------------
module store_unit
  import store_unit_pkg::*;
#(
  parameter int XLEN      = STORE_XLEN,
  parameter int NUM_BYTES = XLEN / 8
) (
  input  logic        clk,
  input  logic        rst,
  store_unit_if.slave bus
);

  if (XLEN != STORE_XLEN || NUM_BYTES * 8 != XLEN) begin : g_bad_xlen
    $error("store_unit: only XLEN=32 / NUM_BYTES=4 is supported");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 load;
  logic                 req_ready_c, stall_c, misaligned_c;

  logic [NUM_BYTES-1:0] align_mbe;
  logic [XLEN-1:0]      align_wdata;
  logic                 align_illegal;

  logic                 dmem_write_q;
  logic [XLEN-1:0]      addr_q, wdata_q;
  logic [NUM_BYTES-1:0] mbe_q;

  store_align u_align (
    .funct3   (bus.req_funct3),
    .addr_off (bus.req_addr[1:0]),
    .data     (bus.req_data),
    .mbe      (align_mbe),
    .wdata    (align_wdata),
    .illegal  (align_illegal)
  );

  // Next state and per-cycle handshake. A request is only judged legal or
  // illegal in a cycle where it could actually be taken; otherwise it waits.
  always_comb begin
    state_d      = state_q;
    load         = 1'b0;
    req_ready_c  = 1'b0;
    stall_c      = 1'b0;
    misaligned_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (align_illegal) begin
            misaligned_c = 1'b1;
            req_ready_c  = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = WRITE;
`ifdef STORE_BUFFER_EN
            req_ready_c = 1'b1;   // posted: pipeline runs on while busy
`else
            stall_c     = 1'b1;
`endif
          end
        end
      end
      WRITE: begin
`ifdef STORE_BUFFER_EN
        if (bus.req_valid) begin
          if (bus.dmem_resp) begin
            if (align_illegal) begin
              // Outstanding write completes; the bad request is dropped.
              misaligned_c = 1'b1;
              req_ready_c  = 1'b1;
              state_d      = IDLE;
            end else begin
              // Chain the next store into the freed buffer entry.
              load        = 1'b1;
              req_ready_c = 1'b1;
            end
          end else begin
            stall_c = 1'b1;
          end
        end else if (bus.dmem_resp) begin
          state_d = IDLE;
        end
`else
        // MEM holds the store in place until the cache response retires it.
        if (bus.dmem_resp) begin
          state_d     = IDLE;
          req_ready_c = bus.req_valid;
        end else begin
          stall_c = bus.req_valid;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      dmem_write_q <= 1'b0;
      // NOTE: the write-port registers are reset too, so the cache port
      // shows defined zeros after reset instead of stale or unknown data.
      addr_q       <= '0;
      wdata_q      <= '0;
      mbe_q        <= '0;
    end else begin
      state_q      <= state_d;
      dmem_write_q <= (state_d == WRITE);
      if (load) begin
        addr_q  <= word_addr(bus.req_addr);
        wdata_q <= align_wdata;
        mbe_q   <= align_mbe;
      end
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.stall        = stall_c;
  assign bus.misaligned   = misaligned_c;
  assign bus.busy         = (state_q == WRITE);
  assign bus.dmem_write   = dmem_write_q;
  assign bus.dmem_address = addr_q;
  assign bus.dmem_wdata   = wdata_q;
  assign bus.dmem_mbe     = mbe_q;

endmodule

// File: tb/tb_store_unit.sv
// -----------------------------------------------------------------------------
// tb_store_unit
// Self-checking bench for store_unit. A transaction-level model (one optional
// pending write plus its address/data/mask) predicts every output each cycle
// from the store rules; directed sequences cover the listed corner cases and a
// randomized phase exercises arbitrary request/response/reset mixes.
// Build with +define+STORE_BUFFER_EN to check the posted-buffer variant.
// -----------------------------------------------------------------------------
module tb_store_unit;
  import store_unit_pkg::*;

`ifdef STORE_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_unit_if bus ();

  store_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    bit ready;
    bit stall;
    bit mis;
    bit load;
    bit done;
  } exp_t;

  bit          m_pend  = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_mbe   = '0;

  function automatic int unsigned size_of(input logic [2:0] f3);
    return (f3 < 3'd3) ? (32'd1 << f3) : 32'd0;
  endfunction

  function automatic bit is_legal(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = size_of(f3);
    return (s != 0) && ((a % s) == 0);
  endfunction

  function automatic logic [3:0] model_mbe(input logic [2:0] f3, input logic [31:0] a);
    int unsigned s = size_of(f3);
    int unsigned m = ((32'd1 << s) - 32'd1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int unsigned s    = size_of(f3);
    logic [31:0] keep = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
    logic [31:0] rep  = (s == 1) ? 32'h0101_0101 : (s == 2) ? 32'h0001_0001 : 32'd1;
    return (d & keep) * rep;
  endfunction

  // A new request can be taken when nothing is pending, or (buffered) when
  // the pending write retires this very cycle.
  function automatic exp_t predict(input bit pend, input bit v, input logic [2:0] f3,
                                   input logic [31:0] a, input bit resp);
    exp_t e;
    bit   can_take;
    e        = '0;
    can_take = !pend || (BUF && resp);
    e.done   = pend && resp;
    if (v) begin
      if (can_take) begin
        if (is_legal(f3, a)) begin
          e.load  = 1'b1;
          e.ready = pend || BUF;
          e.stall = !(pend || BUF);
        end else begin
          e.mis   = 1'b1;
          e.ready = 1'b1;
        end
      end else if (resp) begin
        e.ready = 1'b1;
      end else begin
        e.stall = 1'b1;
      end
    end
    return e;
  endfunction

  // Last sampled outputs (taken on the falling edge)
  bit          o_ready, o_stall, o_mis, o_write, o_busy;
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_mbe;

  // One clock: check outputs against the model mid-cycle, then advance the
  // model on the rising edge. Inputs must be driven before calling.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    e = predict(m_pend, bus.req_valid, bus.req_funct3, bus.req_addr, bus.dmem_resp);
    o_ready = bus.req_ready;  o_stall = bus.stall;  o_mis   = bus.misaligned;
    o_write = bus.dmem_write; o_busy  = bus.busy;   o_addr  = bus.dmem_address;
    o_wdata = bus.dmem_wdata; o_mbe   = bus.dmem_mbe;
    check("req_ready",    32'(o_ready), 32'(e.ready));
    check("stall",        32'(o_stall), 32'(e.stall));
    check("misaligned",   32'(o_mis),   32'(e.mis));
    check("busy",         32'(o_busy),  32'(m_pend));
    check("dmem_write",   32'(o_write), 32'(m_pend));
    check("dmem_address", o_addr,       m_addr);
    check("dmem_wdata",   o_wdata,      m_wdata);
    check("dmem_mbe",     32'(o_mbe),   32'(m_mbe));
    @(posedge clk);
    if (rst) begin
      m_pend = 1'b0; m_addr = '0; m_wdata = '0; m_mbe = '0;
    end else if (e.load) begin
      m_pend  = 1'b1;
      m_addr  = {bus.req_addr[31:2], 2'b00};
      m_wdata = model_wdata(bus.req_funct3, bus.req_data);
      m_mbe   = model_mbe(bus.req_funct3, bus.req_addr);
    end else if (e.done) begin
      m_pend = 1'b0;
    end
    #1;
  endtask

  task automatic drive_req(input bit v, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d);
    bus.req_valid  = v;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_data   = d;
  endtask

  // Present one store and run n cycles. The request is held until req_ready,
  // then dropped. resp_at<0 ties dmem_resp high.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int resp_at, input int n,
                           output int stalls, output int writes, output int ready_k,
                           output int mis_cnt, output logic [31:0] cap_addr,
                           output logic [31:0] cap_wdata, output logic [3:0] cap_mbe);
    stalls = 0; writes = 0; ready_k = -1; mis_cnt = 0;
    cap_addr = '0; cap_wdata = '0; cap_mbe = '0;
    drive_req(1'b1, f3, a, d);
    for (int k = 0; k < n; k++) begin
      bus.dmem_resp = (resp_at < 0) || (k == resp_at);
      cycle();
      stalls  += int'(o_stall);
      writes  += int'(o_write);
      mis_cnt += int'(o_mis);
      if (k == 1) begin
        cap_addr = o_addr; cap_wdata = o_wdata; cap_mbe = o_mbe;
      end
      if (o_ready && ready_k < 0) ready_k = k;
      if (o_ready) bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    bus.dmem_resp = 1'b0;
  endtask

  initial begin
    int          stalls, writes, ready_k, mis_cnt;
    logic [31:0] ca, cw;
    logic [3:0]  cm;

    rst = 1'b1;
    drive_req(1'b0, 3'b000, '0, '0);
    bus.dmem_resp = 1'b0;
    @(posedge clk); #1;

    // Reset state, with a stray response that must be ignored
    cycle();
    bus.dmem_resp = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("reset_busy",  32'(o_busy),  32'd0);
    check("reset_write", 32'(o_write), 32'd0);
    check("reset_addr",  o_addr,       32'd0);
    bus.dmem_resp = 1'b0;

    // SB to the top byte lane, response three cycles after dmem_write rises
    run_store(3'b000, 32'h0000_1003, 32'h0000_00A5, 4, 7, stalls, writes, ready_k, mis_cnt, ca, cw, cm);
    check("sb_addr",    ca,             32'h0000_1000);
    check("sb_mbe",     32'(cm),        32'h8);
    check("sb_wdata",   cw,             32'hA5A5_A5A5);
    check("sb_stalls",  32'(stalls),    BUF ? 32'd0 : 32'd4);
    check("sb_ready_k", 32'(ready_k),   BUF ? 32'd0 : 32'd4);
    check("sb_writes",  32'(writes),    32'd4);

    // SH to the upper half
    run_store(3'b001, 32'h0000_2002, 32'h1234_BEEF, 1, 4, stalls, writes, ready_k, mis_cnt, ca, cw, cm);
    check("sh_mbe",     32'(cm),      32'hC);
    check("sh_wdata",   cw,           32'hBEEF_BEEF);
    check("sh_ready_k", 32'(ready_k), BUF ? 32'd0 : 32'd1);

    // Misaligned SH: dropped, never reaches the cache
    run_store(3'b001, 32'h0000_2001, 32'h1234_BEEF, 2, 4, stalls, writes, ready_k, mis_cnt, ca, cw, cm);
    check("sh_mis_cnt",   32'(mis_cnt), 32'd1);
    check("sh_mis_write", 32'(writes),  32'd0);
    check("sh_mis_ready", 32'(ready_k), 32'd0);

    // SW with the cache responding every cycle
    run_store(3'b010, 32'h0000_3000, 32'hDEAD_BEEF, -1, 4, stalls, writes, ready_k, mis_cnt, ca, cw, cm);
    check("sw_writes", 32'(writes), 32'd1);
    check("sw_stalls", 32'(stalls), BUF ? 32'd0 : 32'd1);
    check("sw_wdata",  cw,          32'hDEAD_BEEF);

    // Unknown width encoding
    run_store(3'b011, 32'h0000_4000, 32'h0BAD_0BAD, 1, 3, stalls, writes, ready_k, mis_cnt, ca, cw, cm);
    check("f3_011_mis",   32'(mis_cnt), 32'd1);
    check("f3_011_write", 32'(writes),  32'd0);
    check("f3_011_stall", 32'(stalls),  32'd0);

`ifdef STORE_BUFFER_EN
    // Back-to-back SWs with the first response two cycles late
    drive_req(1'b1, 3'b010, 32'h0000_0040, 32'h1111_1111);
    bus.dmem_resp = 1'b0;
    cycle();
    check("b2b_first_ready", 32'(o_ready), 32'd1);
    drive_req(1'b1, 3'b010, 32'h0000_0044, 32'h2222_2222);
    cycle();
    check("b2b_wait_stall", 32'(o_stall), 32'd1);
    cycle();
    check("b2b_wait_ready", 32'(o_ready), 32'd0);
    bus.dmem_resp = 1'b1;
    cycle();
    check("b2b_take_ready", 32'(o_ready), 32'd1);
    check("b2b_take_addr",  o_addr,       32'h0000_0040);
    bus.req_valid = 1'b0;
    bus.dmem_resp = 1'b0;
    cycle();
    check("b2b_next_write", 32'(o_write), 32'd1);
    check("b2b_next_addr",  o_addr,       32'h0000_0044);
    bus.dmem_resp = 1'b1;
    cycle();
    bus.dmem_resp = 1'b0;
    cycle();
    check("b2b_done_busy", 32'(o_busy), 32'd0);
`endif

    // Reset while a write is outstanding, then a late response
    drive_req(1'b1, 3'b010, 32'h0000_0080, 32'hCAFE_F00D);
    bus.dmem_resp = 1'b0;
    cycle();
    if (o_ready) bus.req_valid = 1'b0;
    cycle();
    check("rst_mid_busy_before", 32'(o_busy), 32'd1);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    bus.dmem_resp = 1'b1;
    cycle();
    check("rst_mid_write", 32'(o_write), 32'd0);
    check("rst_mid_busy",  32'(o_busy),  32'd0);
    bus.dmem_resp = 1'b0;
    cycle();
    check("rst_mid_late_resp", 32'(o_busy), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int unsigned r  = $urandom_range(0, 9);
      logic [2:0]  f3 = (r < 8) ? 3'(r % 3) : 3'($urandom_range(3, 7));
      logic [31:0] a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      drive_req(($urandom_range(0, 3) != 0), f3, a, $urandom);
      bus.dmem_resp = ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    drive_req(1'b0, 3'b000, '0, '0);
    bus.dmem_resp = 1'b1;
    cycle();
    bus.dmem_resp = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
